serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder: shifts operands LSB-first through a 1-bit full-adder cell.
//  A carry flip-flop chains the cell across cycles.

---
 rtl/fa_cell.sv | 18 +
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fa_cell.sv
// One-bit full adder built from two half-adder stages whose carries are ORed.
module fa_cell (
  output logic s,
  output logic co,
  input  logic x,
  input  logic y,
  input  logic ci
);

  logic hs1, hc1, hc2;

  assign hs1 = x ^ y;
  assign hc1 = x & y;
  assign s   = hs1 ^ ci;
  assign hc2 = hs1 & ci;
  assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands shift LSB-first through one fa_cell,
// with a carry flip-flop chaining the cell across cycles.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d, ps_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, done_q, done_d;
  logic             s_n, c_n;

  fa_cell u_fa (
    .s  (s_n),
    .co (c_n),
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .ci (carry_q)
  );

  // Shifting the concatenation keeps this well-formed even when WIDTH is 1.
  assign ps_shift = WIDTH'({s_n, ps_q} >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new request directly, giving back-to-back adds.
        if (start) begin
          state_d = S_RUN;
          sa_d    = a;
          sb_d    = b;
          ps_d    = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        ps_d    = ps_shift;
        carry_d = c_n;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          cnt_d   = cnt_q;
          sum_d   = ps_shift;
          cout_d  = c_n;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 and WIDTH=1 instances, directed vectors.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    int         edge_n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst8, rst1, start8, start1;
  logic [7:0] a8, b8, sum8;
  logic [0:0] a1, b1, sum1;
  logic       busy8, done8, cout8, busy1, done1, cout1;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a done pulse appears.
  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      chk("w8 done/busy exclusive", int'(busy8), 0);
      if (q8.size() == 0) begin
        chk("w8 unexpected done", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("w8 sum", int'(sum8), int'(e.sum));
        chk("w8 cout", int'(cout8), int'(e.cout));
        chk("w8 done edge", cyc, e.edge_n);
      end
    end
    if (done1) begin
      chk("w1 done/busy exclusive", int'(busy1), 0);
      if (q1.size() == 0) begin
        chk("w1 unexpected done", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("w1 sum", int'(sum1), int'(e.sum));
        chk("w1 cout", int'(cout1), int'(e.cout));
        chk("w1 done edge", cyc, e.edge_n);
      end
    end
  end

  // Called at a negedge; leaves start low at the negedge after the accepting edge.
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] es, input logic ec, input bit push);
    exp_t e;
    start8 = 1'b1;
    a8 = av;
    b8 = bv;
    if (push) begin
      e.sum = es; e.cout = ec; e.edge_n = cyc + 1 + 8;
      q8.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'h00;
    b8 = 8'h00;
  endtask

  task automatic issue1(input logic av, input logic bv, input logic es, input logic ec);
    exp_t e;
    start1 = 1'b1;
    a1 = av;
    b1 = bv;
    e.sum = 8'(es); e.cout = ec; e.edge_n = cyc + 1 + 1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  initial begin
    rst8 = 1'b1; rst1 = 1'b1;
    start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    rst8 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    chk("reset sum", int'(sum8), 0);
    chk("reset cout", int'(cout8), 0);
    chk("reset busy", int'(busy8), 0);
    chk("reset done", int'(done8), 0);

    // Zero add, carry wrap, alternating bits.
    issue8(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    issue8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    repeat (9) @(negedge clk);
    issue8(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b1);
    repeat (9) @(negedge clk);

    // MSB carry-out, with a start pulse mid-RUN that must be ignored.
    issue8(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("busy mid-run", int'(busy8), 1);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    repeat (8) @(negedge clk);
    chk("hold sum after 80+80", int'(sum8), 8'h00);
    chk("hold cout after 80+80", int'(cout8), 1);

    // Async reset three RUN cycles into an add.
    issue8(8'h0F, 8'h01, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    #1;
    chk("async rst sum", int'(sum8), 0);
    chk("async rst cout", int'(cout8), 0);
    chk("async rst busy", int'(busy8), 0);
    chk("async rst done", int'(done8), 0);
    @(negedge clk);
    rst8 = 1'b0;
    repeat (12) @(negedge clk);
    chk("no done after abort", q8.size(), 0);
    issue8(8'h0F, 8'h01, 8'h10, 1'b0, 1'b1);
    repeat (9) @(negedge clk);

    // Back-to-back: second start held during the DONE cycle.
    issue8(8'h10, 8'h20, 8'h30, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    chk("b2b done cycle", int'(done8), 1);
    chk("b2b busy low in done", int'(busy8), 0);
    issue8(8'h3C, 8'h03, 8'h3F, 1'b0, 1'b1);
    chk("b2b busy after reload", int'(busy8), 1);
    repeat (9) @(negedge clk);

    // WIDTH=1: all four operand pairs.
    issue1(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    issue1(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    issue1(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    issue1(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);

    chk("w8 scoreboard drained", q8.size(), 0);
    chk("w1 scoreboard drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
